// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side blocks: parameter legality and derived widths.
package fifo_pkg;

    localparam int unsigned MinBufDepth = 2;

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_rd_buf.sv
// Circular buffer holding words captured from the FIFO until the stream consumer takes them.
module stream_rd_buf
    import fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned OccW  = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] data,
    output logic [OccW-1:0]  occ,
    output logic [PtrW-1:0]  rd_ptr
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]  occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_d;
        end
    end

    // Storage is deliberately not reset; contents are only observed while occ != 0.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign data   = mem_q[rd_ptr_q];
    assign occ    = occ_q;
    assign rd_ptr = rd_ptr_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side companion for a registered-read FIFO: issues reads, captures returning
// words one cycle later and presents them on a valid/ready stream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy
);

    localparam int unsigned   PtrW     = $clog2(BUF_DEPTH);
    localparam int unsigned   OccW     = occ_width(BUF_DEPTH);
    localparam logic [OccW:0] DepthLim = (OccW + 1)'(BUF_DEPTH);

    if (BUF_DEPTH < MinBufDepth) begin : gen_depth_chk
        $error("fifo_stream_reader: BUF_DEPTH must be at least 2");
    end
    if (!is_pow2(BUF_DEPTH)) begin : gen_pow2_chk
        $error("fifo_stream_reader: BUF_DEPTH must be a power of 2");
    end

    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [OccW-1:0]      occ;
    logic [PtrW-1:0]      rd_ptr;
    logic [OccW:0]        pending;
    logic                 push, pop;
    logic                 unused_rd_ptr;

    // Reserve a slot for every word already requested so back-pressure never overflows.
    assign pending    = {1'b0, occ} + {{OccW{1'b0}}, inflight_q};
    assign fifo_rd_en = rst_n && !flush && !fifo_empty && (pending < DepthLim);

    assign m_valid    = rst_n && !flush && (occ != '0);
    assign push       = inflight_q && !flush;
    assign pop        = m_valid && m_ready;
    assign busy       = rst_n && ((occ != '0) || inflight_q);
    assign word_count = rst_n ? count_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + 1'b1;
        end
    end

    stream_rd_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .flush     (flush),
        .data      (m_data),
        .occ       (occ),
        .rd_ptr    (rd_ptr)
    );

    assign unused_rd_ptr = ^rd_ptr;

endmodule
